// File: rtl/dma_window_responder.sv
// dma_window_responder
//
// Responder end of the CNN-controller DMA request interface. It accepts one
// request per 4-phase start/finish handshake. A read request fetches a KxK
// window from the single-port feature-map RAM into the window register:
// K = 2 for pooling reads, K = WIN otherwise. A write request stores one
// result word to RAM.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   dma_start       request level, held by the initiator until dma_finish
//   dma_write       1 = single-word write, 0 = window read
//   dma_pooling     read only: 1 = 2x2 window, 0 = WINxWIN window
//   dma_base_addr   top-left pixel address (read) or target address (write)
//   dma_row_stride  words per image row
//   dma_wdata       word to write
//   dma_finish      request complete, held until dma_start drops
//   dma_busy        high in every state except IDLE
//   window          row-major, entry (r,c) at [(r*WIN+c)*DATA_W +: DATA_W]
//   mem_en, mem_we  RAM access enable / write enable
//   mem_addr        RAM word address
//   mem_wdata       RAM write data
//   mem_rdata       RAM read data, valid one cycle after a read access
module dma_window_responder #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int WIN      = 5,
  parameter int STRIDE_W = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dma_start,
  input  logic                      dma_write,
  input  logic                      dma_pooling,
  input  logic [ADDR_W-1:0]         dma_base_addr,
  input  logic [STRIDE_W-1:0]       dma_row_stride,
  input  logic [DATA_W-1:0]         dma_wdata,
  output logic                      dma_finish,
  output logic                      dma_busy,
  output logic [WIN*WIN*DATA_W-1:0] window,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int CNT_W = $clog2(WIN);
  localparam int NENT  = WIN * WIN;
  localparam int IDX_W = $clog2(NENT);
  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WIN - 1);
  localparam logic [CNT_W-1:0] POOL_LAST = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_DRAIN,
    WR,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [ADDR_W-1:0]   base_reg;
  logic [STRIDE_W-1:0] stride_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [CNT_W-1:0]    k_last;
  logic [ADDR_W-1:0]   row_base;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    c_cnt;
  logic                cap_valid;
  logic [IDX_W-1:0]    cap_idx;
  logic                issue_last;

  assign issue_last = (r_cnt == k_last) && (c_cnt == k_last);
  assign dma_busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // RAM outputs are decoded from the state so that a reset drops mem_en and
  // mem_we on the same edge that returns the FSM to IDLE.
  always_comb begin
    next_state = state;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        if (dma_start) begin
          next_state = dma_write ? WR : RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = row_base + ADDR_W'(c_cnt);
        if (issue_last) begin
          next_state = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        next_state = DONE;
      end
      WR: begin
        mem_en     = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = base_reg;
        mem_wdata  = wdata_reg;
        next_state = DONE;
      end
      DONE: begin
        // Leaving needs finish already shown, so a start that dropped
        // mid-transfer still sees a finish pulse.
        if (dma_finish && !dma_start) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Request latch, issue counters, read-data capture and finish flag.
  // Row addresses are accumulated by adding the stride once per row, and
  // wrap modulo 2^ADDR_W naturally. Each issue records its window index so
  // the returning word lands in the right entry one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_reg   <= '0;
      stride_reg <= '0;
      wdata_reg  <= '0;
      k_last     <= WIN_LAST;
      row_base   <= '0;
      r_cnt      <= '0;
      c_cnt      <= '0;
      cap_valid  <= 1'b0;
      cap_idx    <= '0;
      dma_finish <= 1'b0;
      window     <= '0;
    end else begin
      dma_finish <= (state == DONE) && (next_state == DONE);
      cap_valid  <= (state == RD_ISSUE);
      cap_idx    <= IDX_W'(r_cnt) * IDX_W'(WIN) + IDX_W'(c_cnt);

      case (state)
        IDLE: begin
          if (dma_start) begin
            base_reg   <= dma_base_addr;
            stride_reg <= dma_row_stride;
            wdata_reg  <= dma_wdata;
            k_last     <= dma_pooling ? POOL_LAST : WIN_LAST;
            row_base   <= dma_base_addr;
            r_cnt      <= '0;
            c_cnt      <= '0;
            // A pooling read only refills the top-left 2x2, so the rest
            // of the window is zeroed for the consumers.
            if (!dma_write && dma_pooling) begin
              for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN; c++) begin
                  if (r > 1 || c > 1) begin
                    window[(r*WIN+c)*DATA_W +: DATA_W] <= '0;
                  end
                end
              end
            end
          end
        end
        RD_ISSUE: begin
          if (c_cnt == k_last) begin
            c_cnt    <= '0;
            r_cnt    <= r_cnt + 1'b1;
            row_base <= row_base + ADDR_W'(stride_reg);
          end else begin
            c_cnt <= c_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase

      if (cap_valid) begin
        for (int i = 0; i < NENT; i++) begin
          if (cap_idx == IDX_W'(i)) begin
            window[i*DATA_W +: DATA_W] <= mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_window_responder.sv
// tb_dma_window_responder
//
// Directed bench for dma_window_responder (DATA_W=16, ADDR_W=16, WIN=5,
// STRIDE_W=6). A behavioural single-port RAM with one-cycle read latency
// is preloaded with RAM[a] = a.
module tb_dma_window_responder;

  logic          clk = 1'b0;
  logic          rst;
  logic          dma_start;
  logic          dma_write;
  logic          dma_pooling;
  logic [15:0]   dma_base_addr;
  logic [5:0]    dma_row_stride;
  logic [15:0]   dma_wdata;
  logic          dma_finish;
  logic          dma_busy;
  logic [399:0]  window;
  logic          mem_en;
  logic          mem_we;
  logic [15:0]   mem_addr;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata;

  logic [15:0]   ram [0:65535];

  int            checks = 0;
  int            errors = 0;
  int            n_edges;
  int            en_cnt;
  int            we_cnt;
  int            extra;
  logic [15:0]   we_addr;
  logic [15:0]   we_data;
  logic [15:0]   addr_log [$];

  always #5 clk = ~clk;

  dma_window_responder #(
    .DATA_W  (16),
    .ADDR_W  (16),
    .WIN     (5),
    .STRIDE_W(6)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .dma_start     (dma_start),
    .dma_write     (dma_write),
    .dma_pooling   (dma_pooling),
    .dma_base_addr (dma_base_addr),
    .dma_row_stride(dma_row_stride),
    .dma_wdata     (dma_wdata),
    .dma_finish    (dma_finish),
    .dma_busy      (dma_busy),
    .window        (window),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  // Single-port RAM model: read data appears one cycle after the access.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
      end
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic start, input logic write,
                                input logic pool, input logic [15:0] base,
                                input logic [5:0] stride,
                                input logic [15:0] wdata);
    dma_start      = start;
    dma_write      = write;
    dma_pooling    = pool;
    dma_base_addr  = base;
    dma_row_stride = stride;
    dma_wdata      = wdata;
  endtask

  function automatic logic [15:0] win_at(input int r, input int c);
    return window[(r*5+c)*16 +: 16];
  endfunction

  // Called right after edge 0 (the accepting edge); returns the number of
  // further edges until dma_finish is seen, or the budget if it never is.
  task automatic run_until_finish(input int budget);
    n_edges = 0;
    en_cnt  = 0;
    we_cnt  = 0;
    we_addr = '0;
    we_data = '0;
    addr_log.delete();
    while (!dma_finish && n_edges < budget) begin
      if (mem_en) begin
        en_cnt++;
        addr_log.push_back(mem_addr);
        if (mem_we) begin
          we_cnt++;
          we_addr = mem_addr;
          we_data = mem_wdata;
        end
      end
      step();
      n_edges++;
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin
      ram[a] = a[15:0];
    end
    rst = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0, 6'd0, 16'h0);

    // Reset state
    step();
    step();
    check_output("reset_finish", 32'(dma_finish), 32'd0);
    check_output("reset_busy", 32'(dma_busy), 32'd0);
    check_output("reset_mem_en", 32'(mem_en), 32'd0);
    check_output("reset_mem_we", 32'(mem_we), 32'd0);
    check_output("reset_mem_addr", 32'(mem_addr), 32'd0);
    check_output("reset_mem_wdata", 32'(mem_wdata), 32'd0);
    check_output("reset_window_zero", 32'(window == '0), 32'd1);
    rst = 1'b0;
    step();

    // 5x5 read, base 0, stride 32; request inputs scrambled while busy
    $display("[TB] 5x5 read base 0 stride 32");
    apply_stimulus(1'b1, 1'b0, 1'b0, 16'd0, 6'd32, 16'h0);
    step();
    apply_stimulus(1'b1, 1'b1, 1'b1, 16'h5555, 6'd7, 16'h1234);
    run_until_finish(100);
    check_output("rd5_finish_edge", 32'(n_edges), 32'd27);
    check_output("rd5_mem_en_cycles", 32'(en_cnt), 32'd25);
    check_output("rd5_addr_first", 32'(addr_log.size() > 0 ? addr_log[0] : 16'hDEAD), 32'd0);
    check_output("rd5_addr_r1c1", 32'(addr_log.size() > 6 ? addr_log[6] : 16'hDEAD), 32'd33);
    check_output("rd5_addr_last", 32'(addr_log.size() > 24 ? addr_log[24] : 16'hDEAD), 32'd132);
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        check_output($sformatf("rd5_win_%0d_%0d", r, c), 32'(win_at(r, c)),
                     32'(32*r + c));
      end
    end
    check_output("rd5_busy_done", 32'(dma_busy), 32'd1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0, 6'd0, 16'h0);
    step();
    check_output("rd5_finish_drop", 32'(dma_finish), 32'd0);
    check_output("rd5_idle_busy", 32'(dma_busy), 32'd0);

    // 2x2 pooling read, base 100, stride 28; start drops mid-transfer
    $display("[TB] 2x2 pooling read base 100 stride 28");
    apply_stimulus(1'b1, 1'b0, 1'b1, 16'd100, 6'd28, 16'h0);
    step();
    dma_start = 1'b0;
    run_until_finish(20);
    check_output("pool_finish_edge", 32'(n_edges), 32'd6);
    check_output("pool_mem_en_cycles", 32'(en_cnt), 32'd4);
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        check_output($sformatf("pool_win_%0d_%0d", r, c), 32'(win_at(r, c)),
                     (r < 2 && c < 2) ? 32'(100 + 28*r + c) : 32'd0);
      end
    end
    step();
    check_output("pool_back_idle", 32'(dma_busy), 32'd0);
    check_output("pool_finish_low", 32'(dma_finish), 32'd0);

    // Write 0xBEEF to 1000, then hold start for 10 cycles after finish
    $display("[TB] write 1000 <- BEEF");
    apply_stimulus(1'b1, 1'b1, 1'b0, 16'd1000, 6'd0, 16'hBEEF);
    step();
    run_until_finish(20);
    check_output("wr_finish_edge", 32'(n_edges), 32'd2);
    check_output("wr_we_pulses", 32'(we_cnt), 32'd1);
    check_output("wr_en_cycles", 32'(en_cnt), 32'd1);
    check_output("wr_addr", 32'(we_addr), 32'd1000);
    check_output("wr_data", 32'(we_data), 32'hBEEF);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (mem_en) extra++;
    end
    check_output("hold_no_mem_en", 32'(extra), 32'd0);
    check_output("hold_finish", 32'(dma_finish), 32'd1);
    check_output("hold_busy", 32'(dma_busy), 32'd1);
    dma_start = 1'b0;
    step();
    check_output("hold_drop_idle", 32'(dma_busy), 32'd0);
    check_output("hold_drop_finish", 32'(dma_finish), 32'd0);

    // Readback of the written word: pooling read, stride 0
    apply_stimulus(1'b1, 1'b0, 1'b1, 16'd1000, 6'd0, 16'h0);
    step();
    check_output("restart_busy", 32'(dma_busy), 32'd1);
    check_output("restart_mem_en", 32'(mem_en), 32'd1);
    run_until_finish(20);
    check_output("rb_finish_edge", 32'(n_edges), 32'd6);
    check_output("rb_win_0_0", 32'(win_at(0, 0)), 32'hBEEF);
    check_output("rb_win_0_1", 32'(win_at(0, 1)), 32'd1001);
    check_output("rb_win_1_0", 32'(win_at(1, 0)), 32'hBEEF);
    check_output("rb_win_1_1", 32'(win_at(1, 1)), 32'd1001);
    dma_start = 1'b0;
    step();

    // Address wrap: base FFFE, stride 1, pooling
    $display("[TB] address wrap at FFFE");
    apply_stimulus(1'b1, 1'b0, 1'b1, 16'hFFFE, 6'd1, 16'h0);
    step();
    run_until_finish(20);
    check_output("wrap_count", 32'(addr_log.size()), 32'd4);
    check_output("wrap_a0", 32'(addr_log.size() > 0 ? addr_log[0] : 16'hDEAD), 32'hFFFE);
    check_output("wrap_a1", 32'(addr_log.size() > 1 ? addr_log[1] : 16'hDEAD), 32'hFFFF);
    check_output("wrap_a2", 32'(addr_log.size() > 2 ? addr_log[2] : 16'hDEAD), 32'hFFFF);
    check_output("wrap_a3", 32'(addr_log.size() > 3 ? addr_log[3] : 16'hDEAD), 32'h0000);
    check_output("wrap_win_0_0", 32'(win_at(0, 0)), 32'hFFFE);
    check_output("wrap_win_1_1", 32'(win_at(1, 1)), 32'h0000);
    dma_start = 1'b0;
    step();

    // Reset while issue 12 of a 5x5 read is on the bus
    $display("[TB] reset during 5x5 read");
    apply_stimulus(1'b1, 1'b0, 1'b0, 16'd0, 6'd32, 16'h0);
    step();
    for (int i = 0; i < 11; i++) begin
      step();
    end
    check_output("rst_pre_mem_en", 32'(mem_en), 32'd1);
    check_output("rst_pre_addr", 32'(mem_addr), 32'd65);
    rst = 1'b1;
    step();
    check_output("rst_mem_en", 32'(mem_en), 32'd0);
    check_output("rst_mem_we", 32'(mem_we), 32'd0);
    check_output("rst_busy", 32'(dma_busy), 32'd0);
    check_output("rst_window_zero", 32'(window == '0), 32'd1);
    check_output("rst_finish", 32'(dma_finish), 32'd0);
    rst = 1'b0;
    dma_start = 1'b0;
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (dma_finish || mem_en) extra++;
    end
    check_output("rst_no_partial_finish", 32'(extra), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
